pktbuf_rd_arbiter: RTL and testbench
====================================

Name: pktbuf_rd_arbiter

Overview:
Shares the single packet-buffer read port between two read requesters: requester 0 is the data mover, and requester 1 is the reorder/debug reader. Arbitration is round-robin at packet granularity, so a granted requester keeps the port until it issues its last-flit read. An outstanding-read tag FIFO routes each returned flit back to the requester that issued it. The block sits between the requesters and the pkt_buffer read port.

Parameters:
AWIDTH, 15, packet-buffer address width (matches PKTBUF_AWIDTH)
DWIDTH, 512, read data width
OUTSTANDING, 8, maximum reads in flight; tag FIFO depth (power of 2)

Ports:
Clk  in  1  clock
Rst  in  1  asynchronous reset, active-high
reqN_read  in  1  read request, N=0,1
reqN_addr  in  AWIDTH  read address
reqN_last  in  1  this read is the last flit of the packet
reqN_af  in  1  requester return buffer almost full; no grant while high
reqN_gnt  out  1  combinational grant; a read is accepted when reqN_read & reqN_gnt
reqN_rvalid  out  1  returned data valid
reqN_rdata  out  DWIDTH  returned data
pkt_buffer_readaddress  out  AWIDTH  memory read address
pkt_buffer_read  out  1  memory read strobe
pkt_buffer_readvalid  in  1  memory return valid (any latency, in order)
pkt_buffer_readdata  in  DWIDTH  memory return data
stats_rd0, stats_rd1  out  32  accepted-read counters
err_orphan  out  1  sticky: readvalid arrived with the tag FIFO empty

Behaviour:
- Reset (async, Rst=1):
  - FSM=IDLE, rr_ptr=0, tag FIFO empty.
  - All rvalid, pkt_buffer_read, stats and err_orphan = 0; addresses/data = 0.
- room = (tag_count < OUTSTANDING). A pop in the same cycle is not credited.
- eligN = reqN_read & ~reqN_af & room.
- FSM IDLE:
  - If both eligible, grant the requester at rr_ptr; if one is eligible, grant it; otherwise no grant.
  - Accepted read with last=0 -> OWNN.
  - Accepted read with last=1 -> stay IDLE, rr_ptr = 1-N.
- FSM OWNN:
  - gntN = ~reqN_af & room; gnt of the other requester = 0.
  - Accepted read with last=1 -> IDLE, rr_ptr = 1-N.
  - Owner dropping reqN_read holds ownership (no timeout).
- At most one grant per cycle; the two gnt outputs are never both high.
- Issue path:
  - The accepted read is registered; pkt_buffer_read/readaddress are asserted exactly 1 cycle after acceptance.
  - The tag (requester id) is pushed in the acceptance cycle.
  - statsN increments in the acceptance cycle and wraps at 2^32.
- Return path:
  - On pkt_buffer_readvalid, pop the tag.
  - Registered: reqN_rvalid=1 and reqN_rdata=readdata on the following cycle, for N = popped tag. The other requester's rvalid = 0.
  - Total latency = 1 + memory latency + 1.
- Orphan: readvalid with the tag FIFO empty -> data dropped, no rvalid, err_orphan=1 until reset. Returns still in flight across a reset therefore flag err_orphan.
- Push and pop in the same cycle: tag_count is unchanged; FIFO pointers wrap modulo OUTSTANDING.
- reqN_af asserting while owner: reads pause and ownership is kept; the other requester is not granted.

Test Plan:
- Single requester: req0 reads addr 5,6,7 (last on 7), memory latency 2 -> pkt_buffer_read on cycles t+1..t+3; req0_rvalid on t+4..t+6 with the matching data; stats_rd0=3; FSM returns to IDLE.
- Contention: both requesters hold 2-flit packets from reset -> order is req0 pkt, req1 pkt, req0 pkt; no interleaving within a packet; gnt never both high.
- Outstanding limit: OUTSTANDING=8, memory stalls readvalid -> exactly 8 reads accepted, gnt=0 until the first return, then one more accepted per return.
- Almost full: req1 owner raises req1_af mid-packet while req0 is requesting -> no reads issued and req0_gnt=0; release af -> req1 finishes, then req0 is granted.
- Orphan: readvalid pulse with no outstanding reads -> no rvalid; err_orphan=1 and stays 1 until Rst.
- Reset mid-packet: Rst pulse while in OWN1 with 3 reads in flight -> outputs 0, FSM IDLE, counters 0; the 3 late returns set err_orphan.

Source files
------------

// File: rtl/pktbuf_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// pktbuf_rd_arbiter_if.sv
// Interfaces used by pktbuf_rd_arbiter.
//
// pktbuf_rd_req_if : one read requester <-> arbiter
//   read    requester -> arbiter   read request
//   addr    requester -> arbiter   packet-buffer read address
//   last    requester -> arbiter   this read is the last flit of the packet
//   af      requester -> arbiter   requester return buffer almost full
//   gnt     arbiter -> requester   combinational grant (accept = read & gnt)
//   rvalid  arbiter -> requester   returned data valid (registered)
//   rdata   arbiter -> requester   returned data (registered)
//   modport master = requester side, modport slave = arbiter side
//
// pktbuf_mem_if : arbiter <-> packet-buffer read port
//   readaddress  arbiter -> memory  read address
//   read         arbiter -> memory  read strobe
//   readvalid    memory -> arbiter  return valid (in order, any latency)
//   readdata     memory -> arbiter  return data
//   modport master = arbiter side, modport slave = memory side
// ---------------------------------------------------------------------------

interface pktbuf_rd_req_if #(
  parameter int AWIDTH = 15,
  parameter int DWIDTH = 512
);
  logic              read;
  logic [AWIDTH-1:0] addr;
  logic              last;
  logic              af;
  logic              gnt;
  logic              rvalid;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output read, addr, last, af,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  read, addr, last, af,
    output gnt, rvalid, rdata
  );
endinterface

interface pktbuf_mem_if #(
  parameter int AWIDTH = 15,
  parameter int DWIDTH = 512
);
  logic [AWIDTH-1:0] readaddress;
  logic              read;
  logic              readvalid;
  logic [DWIDTH-1:0] readdata;

  modport master (
    output readaddress, read,
    input  readvalid, readdata
  );

  modport slave (
    input  readaddress, read,
    output readvalid, readdata
  );
endinterface

// File: rtl/pktbuf_rd_arbiter.sv
// ---------------------------------------------------------------------------
// pktbuf_rd_arbiter
// Shares the single packet-buffer read port between two requesters
// (req0 = data mover, req1 = reorder/debug reader). Arbitration is
// round-robin at packet granularity: once a requester is granted a non-last
// flit it owns the port until it issues its last-flit read. A tag FIFO of
// requester ids, one entry per read in flight, steers each in-order return
// back to the requester that issued it.
//
// Ports
//   Clk, Rst     clock, asynchronous active-high reset
//   req0, req1   requester interfaces (pktbuf_rd_req_if.slave)
//   mem          packet-buffer read port (pktbuf_mem_if.master)
//   stats_rd0/1  accepted-read counters, wrap at 2^32
//   err_orphan   sticky: a return arrived with no read outstanding
//
// Latency: read accepted in cycle t -> mem.read in t+1; return steered to the
// requester one cycle after mem.readvalid.
// ---------------------------------------------------------------------------

module pktbuf_rd_arbiter #(
  parameter int AWIDTH      = 15,
  parameter int DWIDTH      = 512,
  parameter int OUTSTANDING = 8
) (
  input  logic                Clk,
  input  logic                Rst,
  pktbuf_rd_req_if.slave      req0,
  pktbuf_rd_req_if.slave      req1,
  pktbuf_mem_if.master        mem,
  output logic [31:0]         stats_rd0,
  output logic [31:0]         stats_rd1,
  output logic                err_orphan
);

  localparam int PTRW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNTW = $clog2(OUTSTANDING + 1);
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(OUTSTANDING - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Pointer increment with explicit wrap so a non-power-of-2 depth still
  // stays inside the tag array.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = {PTRW{1'b0}};
    end else begin
      ptr_inc = p + PTRW'(1);
    end
  endfunction

  // FSM and round-robin pointer
  state_e state_q, state_d;
  logic   rr_ptr_q, rr_ptr_d;

  // Arbitration terms
  logic room_s;
  logic elig0_s, elig1_s;
  logic gnt0_s, gnt1_s;
  logic acc0_s, acc1_s;

  // Issue path registers
  logic              rd_strobe_q, rd_strobe_d;
  logic [AWIDTH-1:0] rd_addr_q,   rd_addr_d;

  // Tag FIFO (one bit per entry: requester id)
  logic [OUTSTANDING-1:0] tag_mem_q, tag_mem_d;
  logic [PTRW-1:0]        wr_ptr_q,  wr_ptr_d;
  logic [PTRW-1:0]        rd_ptr_q,  rd_ptr_d;
  logic [CNTW-1:0]        tag_count_q, tag_count_d;
  logic                   push_s, pop_s, orphan_s, head_tag_s, fifo_empty_s;

  // Return path registers
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DWIDTH-1:0] rdata0_q,  rdata0_d;
  logic [DWIDTH-1:0] rdata1_q,  rdata1_d;

  // Statistics and error
  logic [31:0] stats0_q, stats0_d;
  logic [31:0] stats1_q, stats1_d;
  logic        orphan_q, orphan_d;

  // Eligibility: a pop in this cycle does not free room until next cycle.
  always_comb begin
    room_s  = (tag_count_q < CNT_MAX);
    elig0_s = req0.read & ~req0.af & room_s;
    elig1_s = req1.read & ~req1.af & room_s;
  end

  // FSM state register and round-robin pointer
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // FSM next state: ownership is entered on a non-last accept and released
  // only by the owner's last-flit accept; the pointer then favours the other.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (acc0_s) begin
          if (req0.last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = 1'b1;
          end else begin
            state_d  = ST_OWN0;
          end
        end else if (acc1_s) begin
          if (req1.last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = 1'b0;
          end else begin
            state_d  = ST_OWN1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0: begin
        if (acc0_s & req0.last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = 1'b1;
        end else begin
          state_d = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (acc1_s & req1.last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = 1'b0;
        end else begin
          state_d = ST_OWN1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        rr_ptr_d = 1'b0;
      end
    endcase
  end

  // FSM outputs: grants. An owner is granted whenever it has room and its
  // return buffer is not almost full, whether or not it is requesting, and
  // the other requester is locked out for the whole packet.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (elig0_s & elig1_s) begin
          gnt0_s = ~rr_ptr_q;
          gnt1_s = rr_ptr_q;
        end else begin
          gnt0_s = elig0_s;
          gnt1_s = elig1_s;
        end
      end
      ST_OWN0: begin
        gnt0_s = ~req0.af & room_s;
      end
      ST_OWN1: begin
        gnt1_s = ~req1.af & room_s;
      end
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
    acc0_s = req0.read & gnt0_s;
    acc1_s = req1.read & gnt1_s;
  end

  // Issue path: register the accepted read; address holds when idle.
  always_comb begin
    rd_strobe_d = acc0_s | acc1_s;
    if (acc0_s) begin
      rd_addr_d = req0.addr;
    end else if (acc1_s) begin
      rd_addr_d = req1.addr;
    end else begin
      rd_addr_d = rd_addr_q;
    end
  end

  // Tag FIFO: push the requester id on accept, pop on each return. A return
  // with nothing outstanding is an orphan and does not pop.
  always_comb begin
    push_s       = acc0_s | acc1_s;
    fifo_empty_s = (tag_count_q == {CNTW{1'b0}});
    pop_s        = mem.readvalid & ~fifo_empty_s;
    orphan_s     = mem.readvalid & fifo_empty_s;
    head_tag_s   = tag_mem_q[rd_ptr_q];

    tag_mem_d = tag_mem_q;
    if (push_s) begin
      tag_mem_d[wr_ptr_q] = acc1_s;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   tag_count_d = tag_count_q + CNTW'(1);
      2'b01:   tag_count_d = tag_count_q - CNTW'(1);
      default: tag_count_d = tag_count_q;
    endcase
  end

  // Return path: steer popped data to the requester named by the head tag.
  always_comb begin
    rvalid0_d = pop_s & ~head_tag_s;
    rvalid1_d = pop_s & head_tag_s;
    if (rvalid0_d) begin
      rdata0_d = mem.readdata;
    end else begin
      rdata0_d = rdata0_q;
    end
    if (rvalid1_d) begin
      rdata1_d = mem.readdata;
    end else begin
      rdata1_d = rdata1_q;
    end
  end

  // Statistics counters (natural 32-bit wrap) and sticky orphan flag
  always_comb begin
    stats0_d = stats0_q + (acc0_s ? 32'd1 : 32'd0);
    stats1_d = stats1_q + (acc1_s ? 32'd1 : 32'd0);
    orphan_d = orphan_q | orphan_s;
  end

  // Datapath registers: issue, tag FIFO, return, stats, error
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_strobe_q <= 1'b0;
      rd_addr_q   <= {AWIDTH{1'b0}};
      tag_mem_q   <= {OUTSTANDING{1'b0}};
      wr_ptr_q    <= {PTRW{1'b0}};
      rd_ptr_q    <= {PTRW{1'b0}};
      tag_count_q <= {CNTW{1'b0}};
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= {DWIDTH{1'b0}};
      rdata1_q    <= {DWIDTH{1'b0}};
      stats0_q    <= 32'd0;
      stats1_q    <= 32'd0;
      orphan_q    <= 1'b0;
    end else begin
      rd_strobe_q <= rd_strobe_d;
      rd_addr_q   <= rd_addr_d;
      tag_mem_q   <= tag_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_count_q <= tag_count_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      stats0_q    <= stats0_d;
      stats1_q    <= stats1_d;
      orphan_q    <= orphan_d;
    end
  end

  assign req0.gnt        = gnt0_s;
  assign req1.gnt        = gnt1_s;
  assign req0.rvalid     = rvalid0_q;
  assign req1.rvalid     = rvalid1_q;
  assign req0.rdata      = rdata0_q;
  assign req1.rdata      = rdata1_q;
  assign mem.read        = rd_strobe_q;
  assign mem.readaddress = rd_addr_q;
  assign stats_rd0       = stats0_q;
  assign stats_rd1       = stats1_q;
  assign err_orphan      = orphan_q;

endmodule

// File: tb/tb_pktbuf_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pktbuf_rd_arbiter
// Directed scenarios followed by a randomized phase. A packet-level model
// (owner / round-robin turn, queue of outstanding requester ids, in-order
// memory with per-read latency) predicts every output each cycle.
// ---------------------------------------------------------------------------

module tb_pktbuf_rd_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 512;
  localparam int OUT = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  pktbuf_rd_req_if #(.AWIDTH(AW), .DWIDTH(DW)) r0 ();
  pktbuf_rd_req_if #(.AWIDTH(AW), .DWIDTH(DW)) r1 ();
  pktbuf_mem_if    #(.AWIDTH(AW), .DWIDTH(DW)) m  ();
  logic [31:0] stats_rd0, stats_rd1;
  logic        err_orphan;

  pktbuf_rd_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .OUTSTANDING(OUT)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .req0       (r0),
    .req1       (r1),
    .mem        (m),
    .stats_rd0  (stats_rd0),
    .stats_rd1  (stats_rd1),
    .err_orphan (err_orphan)
  );

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;

  // requester drivers
  bit act[2];
  bit afv[2];
  int plen[2];
  int flit[2];
  int base[2];
  int acc_log[$];

  // reference model
  int              m_owner;   // -1 = nobody owns the port
  int              m_rr;      // requester favoured on a tie
  int              m_tags[$]; // ids of reads in flight, oldest first
  bit              m_rd;
  int              m_addr;
  int              m_ret;     // -1 = no return this cycle
  logic [DW-1:0]   m_retdata;
  logic [31:0]     m_stats[2];
  bit              m_orph;

  // memory model
  typedef struct { int addr; int ready; } mreq_t;
  mreq_t mem_q[$];
  int lat;
  bit stall;
  bit inject;

  function automatic logic [DW-1:0] mk_data(input int a);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = (a * 32'h9E3779B1) + i;
    return d;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_tags.delete(); m_rd = 0; m_addr = 0;
    m_ret = -1; m_stats[0] = 32'd0; m_stats[1] = 32'd0; m_orph = 0;
    flit[0] = 0; flit[1] = 0;
  endtask

  // one clock cycle: drive, compare at negedge, advance the model
  task automatic cycle();
    bit g[2];
    bit el[2];
    bit acc[2];
    bit room;
    bit rv;
    logic [DW-1:0] rd;
    mreq_t e;

    r0.read = act[0]; r0.addr = AW'(base[0] + flit[0]); r0.last = (flit[0] == plen[0] - 1); r0.af = afv[0];
    r1.read = act[1]; r1.addr = AW'(base[1] + flit[1]); r1.last = (flit[1] == plen[1] - 1); r1.af = afv[1];

    if (m_rd) begin
      e.addr = m_addr; e.ready = cyc + lat;
      mem_q.push_back(e);
    end
    rv = 1'b0; rd = '0;
    if (inject) begin
      rv = 1'b1; rd = {DW{1'b1}};
    end else if (!stall && mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      rv = 1'b1; rd = mk_data(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    m.readvalid = rv; m.readdata = rd;

    @(negedge Clk);
    room  = (m_tags.size() < OUT);
    el[0] = act[0] && !afv[0] && room;
    el[1] = act[1] && !afv[1] && room;
    g[0] = 1'b0; g[1] = 1'b0;
    if (m_owner < 0) begin
      if (el[0] && el[1]) g[m_rr] = 1'b1;
      else if (el[0])     g[0] = 1'b1;
      else if (el[1])     g[1] = 1'b1;
    end else begin
      g[m_owner] = !afv[m_owner] && room;
    end

    check("gnt0", r0.gnt, g[0]);
    check("gnt1", r1.gnt, g[1]);
    check("pkt_read", m.read, m_rd);
    if (m_rd) check("pkt_addr", m.readaddress, m_addr);
    check("rvalid0", r0.rvalid, m_ret == 0);
    check("rvalid1", r1.rvalid, m_ret == 1);
    if (m_ret == 0) check("rdata0", r0.rdata, m_retdata);
    if (m_ret == 1) check("rdata1", r1.rdata, m_retdata);
    check("stats0", stats_rd0, m_stats[0]);
    check("stats1", stats_rd1, m_stats[1]);
    check("err_orphan", err_orphan, m_orph);

    acc[0] = act[0] && g[0];
    acc[1] = act[1] && g[1];
    m_rd = 0;
    m_ret = -1;
    if (rv) begin
      if (m_tags.size() == 0) m_orph = 1;
      else begin
        m_ret = m_tags.pop_front();
        m_retdata = rd;
      end
    end
    for (int n = 0; n < 2; n++) begin
      if (acc[n]) begin
        m_rd = 1;
        m_addr = (base[n] + flit[n]) & 32'h7FFF;
        m_stats[n] = m_stats[n] + 32'd1;
        m_tags.push_back(n);
        acc_log.push_back(n);
        if (flit[n] == plen[n] - 1) begin
          m_owner = -1; m_rr = 1 - n;
          flit[n] = 0; base[n] = (base[n] + 16) & 32'h7FFF;
        end else begin
          m_owner = n;
          flit[n] = flit[n] + 1;
        end
      end
    end

    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    act[0] = 0; act[1] = 0;
    r0.read = 1'b0; r1.read = 1'b0;
    m.readvalid = 1'b0;
    #2;
    check("rst_gnt0", r0.gnt, 1'b0);
    check("rst_gnt1", r1.gnt, 1'b0);
    check("rst_read", m.read, 1'b0);
    check("rst_addr", m.readaddress, '0);
    check("rst_rvalid0", r0.rvalid, 1'b0);
    check("rst_rvalid1", r1.rvalid, 1'b0);
    check("rst_rdata0", r0.rdata, '0);
    check("rst_rdata1", r1.rdata, '0);
    check("rst_stats0", stats_rd0, 32'd0);
    check("rst_stats1", stats_rd1, 32'd0);
    check("rst_orphan", err_orphan, 1'b0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    cyc++;
    model_reset();
  endtask

  task automatic drain();
    act[0] = 0; act[1] = 0; stall = 0;
    for (int i = 0; i < 80 && (mem_q.size() > 0 || m_tags.size() > 0 || m_rd || m_ret >= 0); i++) cycle();
  endtask

  task automatic run_until(input int n);
    for (int i = 0; i < 60 && acc_log.size() < n; i++) cycle();
  endtask

  initial begin
    int ord[6];
    r0.read = 1'b0; r0.addr = '0; r0.last = 1'b0; r0.af = 1'b0;
    r1.read = 1'b0; r1.addr = '0; r1.last = 1'b0; r1.af = 1'b0;
    m.readvalid = 1'b0; m.readdata = '0;
    act[0] = 0; act[1] = 0; afv[0] = 0; afv[1] = 0;
    plen[0] = 1; plen[1] = 1; base[0] = 0; base[1] = 0;
    lat = 2; stall = 0; inject = 0;
    model_reset();
    #1;
    do_reset();

    // single requester: 5,6,7 with last on 7, memory latency 2
    base[0] = 5; plen[0] = 3; act[0] = 1; lat = 2;
    acc_log.delete();
    run_until(3);
    act[0] = 0;
    repeat (8) cycle();
    check("t1_stats0", stats_rd0, 32'd3);
    check("t1_accepts", acc_log.size(), 3);

    // contention: two-flit packets from both, fresh from reset
    drain();
    do_reset();
    base[0] = 100; base[1] = 200; plen[0] = 2; plen[1] = 2;
    act[0] = 1; act[1] = 1;
    acc_log.delete();
    run_until(6);
    act[0] = 0; act[1] = 0;
    ord = '{0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++)
      check("t2_order", (i < acc_log.size()) ? acc_log[i] : -1, ord[i]);

    // outstanding limit with a stalled memory
    drain();
    stall = 1; lat = 1;
    base[0] = 400; plen[0] = 100; act[0] = 1;
    acc_log.delete();
    repeat (15) cycle();
    check("t3_limit", acc_log.size(), OUT);
    stall = 0;
    repeat (12) cycle();
    check("t3_more", acc_log.size() > OUT, 1'b1);
    drain();

    // almost full while req1 owns the port
    do_reset();
    lat = 2;
    base[1] = 300; plen[1] = 4; act[1] = 1;
    acc_log.delete();
    run_until(2);
    afv[1] = 1; base[0] = 500; plen[0] = 2; act[0] = 1;
    repeat (5) cycle();
    check("t4_paused", acc_log.size(), 2);
    afv[1] = 0;
    run_until(6);
    act[0] = 0; act[1] = 0;
    ord = '{1, 1, 1, 1, 0, 0};
    for (int i = 2; i < 6; i++)
      check("t4_order", (i < acc_log.size()) ? acc_log[i] : -1, ord[i]);

    // orphan return
    drain();
    inject = 1; cycle(); inject = 0;
    repeat (3) cycle();
    check("t5_orphan", err_orphan, 1'b1);
    base[0] = 600; plen[0] = 1; act[0] = 1;
    repeat (4) cycle();
    act[0] = 0;
    drain();
    check("t5_sticky", err_orphan, 1'b1);

    // reset while req1 owns the port with three reads in flight
    do_reset();
    lat = 6;
    base[1] = 700; plen[1] = 8; act[1] = 1;
    acc_log.delete();
    run_until(3);
    act[1] = 0;
    cycle();
    do_reset();
    repeat (10) cycle();
    check("t6_orphan", err_orphan, 1'b1);
    check("t6_stats1", stats_rd1, 32'd0);

    // randomized traffic
    drain();
    do_reset();
    for (int i = 0; i < 700; i++) begin
      for (int n = 0; n < 2; n++) begin
        act[n] = ($urandom_range(0, 3) != 0);
        afv[n] = ($urandom_range(0, 7) == 0);
        if (flit[n] == 0) plen[n] = $urandom_range(1, 3);
      end
      stall = ($urandom_range(0, 5) == 0);
      lat = $urandom_range(1, 5);
      cycle();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
